md_scheduler: RTL

- Sequences the multi-cycle multiply/divide resource and the HI/LO registers for the 5-stage MIPS pipeline.
- Accepts MD operations issued from the E stage and models fixed MULT/DIV latencies with a countdown.
- Commits results to HI/LO and drives a stall request so D-stage MD instructions wait while the unit is busy.
- The stall request is OR-ed into the existing stall logic; MFHI/MFLO read hi/lo in E.

---
 rtl/md_scheduler_pkg.sv | 24 ++
 rtl/md_compute.sv | 66 ++++++
 rtl/md_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/md_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// md_scheduler_pkg
// Shared definitions for the multiply/divide scheduler and the decoder that
// produces md_op_e / md_use_d: MD opcode encodings, default latencies and the
// countdown width.
// -----------------------------------------------------------------------------
package md_scheduler_pkg;

   // E-stage MD opcode encodings (3 bits); 3'd7 is reserved and acts as NONE
   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;
   localparam logic [2:0] MD_RSVD  = 3'd7;

   // Default busy latencies (legal range 1..15, fits the 4-bit countdown)
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;
   localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/md_compute.sv
// -----------------------------------------------------------------------------
// md_compute
// Purely combinational MULT/MULTU/DIV/DIVU datapath producing {hi, lo}.
// Ports:
//   md_op  in  3   MD opcode (only 1..4 produce a result, others give 0)
//   a      in  32  rs operand (multiplicand / dividend)
//   b      in  32  rt operand (multiplier / divisor)
//   result out 64  {hi, lo}; for divides hi=remainder, lo=quotient
// Divide by zero yields hi=a, lo=all ones. Signed 0x80000000 / -1 yields
// lo=0x80000000, hi=0.
// -----------------------------------------------------------------------------
module md_compute
   import md_scheduler_pkg::*;
(
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result
);

   logic               div_zero_s;
   logic               div_ovf_s;
   logic [31:0]        sden_s;
   logic [31:0]        uden_s;
   logic signed [63:0] smul_s;
   logic [63:0]        umul_s;
   logic signed [31:0] squot_s;
   logic signed [31:0] srem_s;
   logic [31:0]        uquot_s;
   logic [31:0]        urem_s;

   assign div_zero_s = (b == 32'd0);
   assign div_ovf_s  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

   // Divisors are forced to 1 in the special cases so the dividers never see
   // a zero or overflowing operand; dividing by 1 also gives the overflow
   // answer directly (quotient = a = 0x80000000, remainder = 0).
   assign sden_s = (div_zero_s || div_ovf_s) ? 32'd1 : b;
   assign uden_s = div_zero_s ? 32'd1 : b;

   assign smul_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign umul_s  = {32'd0, a} * {32'd0, b};
   assign squot_s = $signed(a) / $signed(sden_s);
   assign srem_s  = $signed(a) % $signed(sden_s);
   assign uquot_s = a / uden_s;
   assign urem_s  = a % uden_s;

   // Result select by opcode, with divide-by-zero override
   always_comb begin
      result = 64'd0;
      case (md_op)
         MD_MULT:  result = smul_s;
         MD_MULTU: result = umul_s;
         MD_DIV: begin
            if (div_zero_s) result = {a, 32'hFFFF_FFFF};
            else            result = {srem_s, squot_s};
         end
         MD_DIVU: begin
            if (div_zero_s) result = {a, 32'hFFFF_FFFF};
            else            result = {urem_s, uquot_s};
         end
         default:  result = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_scheduler.sv
// -----------------------------------------------------------------------------
// md_scheduler
// Sequences the multi-cycle multiply/divide unit and the HI/LO registers.
// The result is captured at issue; a countdown models the fixed latency and
// commits it to HI/LO when it expires.
// Ports:
//   clk       in  1   rising-edge clock
//   rst_n     in  1   asynchronous active-low reset
//   md_op_e   in  3   E-stage MD opcode
//   a_e, b_e  in  32  forwarded rs / rt values in E
//   md_use_d  in  1   D-stage instruction uses the MD unit / HI / LO
//   start     out 1   issue accepted this cycle (combinational)
//   busy      out 1   operation in flight (registered)
//   md_stall  out 1   hold the D-stage MD instruction (combinational)
//   hi, lo    out 32  architectural HI / LO (registered)
//   md_err    out 1   sticky: an MD op arrived while busy
// -----------------------------------------------------------------------------
module md_scheduler
   import md_scheduler_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  md_op_e,
   input  logic [31:0] a_e,
   input  logic [31:0] b_e,
   input  logic        md_use_d,
   output logic        start,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        md_err
);

   logic [CNT_W-1:0] count_r;
   logic [31:0]      res_hi_r;
   logic [31:0]      res_lo_r;
   logic [63:0]      result_s;
   logic [CNT_W-1:0] latency_s;
   logic             issue_op_s;
   logic             md_op_s;

   md_compute u_compute (
      .md_op  (md_op_e),
      .a      (a_e),
      .b      (b_e),
      .result (result_s)
   );

   // Opcode classification and per-operation latency
   always_comb begin
      issue_op_s = 1'b0;
      md_op_s    = 1'b0;
      latency_s  = CNT_W'(MULT_CYCLES);
      case (md_op_e)
         MD_MULT, MD_MULTU: begin
            issue_op_s = 1'b1;
            md_op_s    = 1'b1;
            latency_s  = CNT_W'(MULT_CYCLES);
         end
         MD_DIV, MD_DIVU: begin
            issue_op_s = 1'b1;
            md_op_s    = 1'b1;
            latency_s  = CNT_W'(DIV_CYCLES);
         end
         MD_MTHI, MD_MTLO: begin
            issue_op_s = 1'b0;
            md_op_s    = 1'b1;
            latency_s  = CNT_W'(MULT_CYCLES);
         end
         default: begin
            issue_op_s = 1'b0;
            md_op_s    = 1'b0;
            latency_s  = CNT_W'(MULT_CYCLES);
         end
      endcase
   end

   assign start    = issue_op_s & ~busy;
   // Stall covers the issue cycle too so a back-to-back MD op in D is held
   assign md_stall = md_use_d & (start | busy);

   // Countdown, HI/LO commit, MTHI/MTLO writes and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         count_r  <= '0;
         res_hi_r <= 32'd0;
         res_lo_r <= 32'd0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         md_err   <= 1'b0;
      end else if (busy) begin
         // Any MD op while busy is dropped and flagged
         if (md_op_s) begin
            md_err <= 1'b1;
         end
         if (count_r == CNT_W'(1)) begin
            hi      <= res_hi_r;
            lo      <= res_lo_r;
            busy    <= 1'b0;
            count_r <= '0;
         end else begin
            count_r <= count_r - CNT_W'(1);
         end
      end else begin
         case (md_op_e)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
               res_hi_r <= result_s[63:32];
               res_lo_r <= result_s[31:0];
               count_r  <= latency_s;
               busy     <= 1'b1;
            end
            MD_MTHI: hi <= a_e;
            MD_MTLO: lo <= a_e;
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
